// File: rtl/score_level_keeper_pkg.sv
// Shared types and default sizing for the score/level keeper and the
// display / speed-control blocks that consume its outputs.
package score_level_keeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int unsigned SLK_SCORE_W    = 32;
  localparam int unsigned SLK_POINTS_W   = 4;
  localparam int unsigned SLK_LEVEL_W    = 4;
  localparam int unsigned SLK_LEVEL_STEP = 16;
  localparam int unsigned SLK_MAX_LEVEL  = 15;

endpackage

// File: rtl/score_evt_edge.sv
// Registers a raw game-event level and produces a one-cycle rising-edge
// pulse, so an input held high is counted only once.
module score_evt_edge (
  input  logic clk,
  input  logic rst,
  input  logic evt_i,
  output logic rise_c
);

  logic evt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= evt_i;
    end
  end

  assign rise_c = evt_i & ~evt_q;

endmodule

// File: rtl/score_level_keeper.sv
// Score/level keeper: weighted saturating score, level tracking with a
// level-up pulse, and an IDLE/PLAY/OVER game FSM. Optional high-score
// tracking is enabled with the SCORE_HISCORE_EN macro.
module score_level_keeper
  import score_level_keeper_pkg::*;
#(
  parameter int unsigned SCORE_W    = SLK_SCORE_W,
  parameter int unsigned POINTS_W   = SLK_POINTS_W,
  parameter int unsigned LEVEL_W    = SLK_LEVEL_W,
  parameter int unsigned LEVEL_STEP = SLK_LEVEL_STEP,
  parameter int unsigned MAX_LEVEL  = SLK_MAX_LEVEL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                gameover,
  input  logic                evt,
  input  logic [POINTS_W-1:0] evt_points,
  output logic [SCORE_W-1:0]  score,
  output logic [LEVEL_W-1:0]  level,
  output logic                levelup,
  output logic                playing,
  output logic                over,
  output logic                saturated
`ifdef SCORE_HISCORE_EN
  ,
  output logic [SCORE_W-1:0]  hiscore,
  output logic                new_hi
`endif
);

  localparam int unsigned ACC_W     = $clog2(LEVEL_STEP) + 1;
  localparam int unsigned ACC_SUM_W = ACC_W + 1;
  localparam int unsigned SUM_W     = SCORE_W + 1;

  // One level per event is only guaranteed if a single event cannot span a step.
  if (LEVEL_STEP < (2 ** POINTS_W)) begin : g_bad_step
    $error("LEVEL_STEP must exceed the largest per-event point value");
  end
  if (MAX_LEVEL >= (2 ** LEVEL_W)) begin : g_bad_max_level
    $error("MAX_LEVEL must fit in LEVEL_W bits");
  end

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               levelup_q, levelup_d;
  logic               playing_q, over_q, saturated_q;
  logic               evt_rise;
  logic               evt_take;
  logic [SUM_W-1:0]   score_sum;
  logic [ACC_SUM_W-1:0] acc_sum;

  score_evt_edge u_evt_edge (
    .clk    (clk),
    .rst    (rst),
    .evt_i  (evt),
    .rise_c (evt_rise)
  );

  assign score_sum = {1'b0, score_q} + SUM_W'(evt_points);
  assign acc_sum   = {1'b0, acc_q} + ACC_SUM_W'(evt_points);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      level_q     <= '0;
      acc_q       <= '0;
      levelup_q   <= 1'b0;
      playing_q   <= 1'b0;
      over_q      <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      level_q     <= level_d;
      acc_q       <= acc_d;
      levelup_q   <= levelup_d;
      playing_q   <= (state_d == ST_PLAY);
      over_q      <= (state_d == ST_OVER);
      saturated_q <= (score_d == {SCORE_W{1'b1}});
    end
  end

  // Start always (re)enters PLAY and wins over gameover and events in that cycle.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    level_d   = level_q;
    acc_d     = acc_q;
    levelup_d = 1'b0;
    evt_take  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (start) begin
          state_d = ST_PLAY;
        end else if (gameover) begin
          state_d = ST_OVER;
        end else begin
          evt_take = evt_rise;
        end
      end
      ST_OVER: begin
        if (start) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      score_d = '0;
      level_d = '0;
      acc_d   = '0;
    end else if (evt_take) begin
      score_d = score_sum[SUM_W-1] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
      if (level_q < LEVEL_W'(MAX_LEVEL)) begin
        if (acc_sum >= ACC_SUM_W'(LEVEL_STEP)) begin
          level_d   = level_q + LEVEL_W'(1);
          acc_d     = ACC_W'(acc_sum - ACC_SUM_W'(LEVEL_STEP));
          levelup_d = 1'b1;
          if (level_d == LEVEL_W'(MAX_LEVEL)) acc_d = '0;
        end else begin
          acc_d = ACC_W'(acc_sum);
        end
      end else begin
        acc_d = '0;
      end
    end
  end

  assign score     = score_q;
  assign level     = level_q;
  assign levelup   = levelup_q;
  assign playing   = playing_q;
  assign over      = over_q;
  assign saturated = saturated_q;

`ifdef SCORE_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q, hiscore_d;
  logic               new_hi_q, new_hi_d;

  // High score survives restarts; only captured on the PLAY -> OVER transition.
  always_comb begin
    hiscore_d = hiscore_q;
    new_hi_d  = 1'b0;
    if ((state_q == ST_PLAY) && (state_d == ST_OVER) && (score_q > hiscore_q)) begin
      hiscore_d = score_q;
      new_hi_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hiscore_q <= '0;
      new_hi_q  <= 1'b0;
    end else begin
      hiscore_q <= hiscore_d;
      new_hi_q  <= new_hi_d;
    end
  end

  assign hiscore = hiscore_q;
  assign new_hi  = new_hi_q;
`endif

endmodule

// File: tb/tb_score_level_keeper.sv
// Bench for score_level_keeper: a default-sized and a small (8-bit score,
// MAX_LEVEL=2) instance share stimulus and are checked against a game model.
module tb_score_level_keeper;

  localparam int unsigned STEP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       gameover = 1'b0;
  logic       evt = 1'b0;
  logic [3:0] evt_points = 4'd0;

  logic [31:0] score_a;
  logic [3:0]  level_a;
  logic        levelup_a, playing_a, over_a, saturated_a;
  logic [7:0]  score_b;
  logic [3:0]  level_b;
  logic        levelup_b, playing_b, over_b, saturated_b;
`ifdef SCORE_HISCORE_EN
  logic [31:0] hiscore_a;
  logic        new_hi_a;
  logic [7:0]  hiscore_b;
  logic        new_hi_b;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  score_level_keeper u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .gameover   (gameover),
    .evt        (evt),
    .evt_points (evt_points),
    .score      (score_a),
    .level      (level_a),
    .levelup    (levelup_a),
    .playing    (playing_a),
    .over       (over_a),
    .saturated  (saturated_a)
`ifdef SCORE_HISCORE_EN
    ,
    .hiscore    (hiscore_a),
    .new_hi     (new_hi_a)
`endif
  );

  score_level_keeper #(.SCORE_W(8), .MAX_LEVEL(2)) u_dut_small (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .gameover   (gameover),
    .evt        (evt),
    .evt_points (evt_points),
    .score      (score_b),
    .level      (level_b),
    .levelup    (levelup_b),
    .playing    (playing_b),
    .over       (over_b),
    .saturated  (saturated_b)
`ifdef SCORE_HISCORE_EN
    ,
    .hiscore    (hiscore_b),
    .new_hi     (new_hi_b)
`endif
  );

  typedef struct {
    int              st;      // 0 idle, 1 play, 2 over
    longint unsigned score;
    int              level;
    int              acc;
    bit              evt_prev;
    bit              lu;
    longint unsigned hi;
    bit              nh;
  } mdl_t;

  mdl_t            m [2];
  longint unsigned mx_score [2];
  int              mx_level [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void mdl_reset(input int i);
    m[i].st = 0; m[i].score = 0; m[i].level = 0; m[i].acc = 0;
    m[i].evt_prev = 1'b0; m[i].lu = 1'b0; m[i].hi = 0; m[i].nh = 1'b0;
  endfunction

  // One clock of game rules applied to the model of instance i.
  function automatic void mdl_step(input int i, input bit s, input bit g, input bit e, input int p);
    bit rise;
    rise = e && !m[i].evt_prev;
    m[i].lu = 1'b0;
    m[i].nh = 1'b0;
    if (s) begin
      m[i].st = 1; m[i].score = 0; m[i].level = 0; m[i].acc = 0;
    end else if (m[i].st == 1 && g) begin
      m[i].st = 2;
      if (m[i].score > m[i].hi) begin
        m[i].hi = m[i].score;
        m[i].nh = 1'b1;
      end
    end else if (m[i].st == 1 && rise) begin
      m[i].score = (m[i].score + longint'(p) > mx_score[i]) ? mx_score[i] : m[i].score + longint'(p);
      if (m[i].level < mx_level[i]) begin
        m[i].acc += p;
        if (m[i].acc >= STEP) begin
          m[i].acc -= STEP;
          m[i].level++;
          m[i].lu = 1'b1;
        end
      end
    end
    m[i].evt_prev = e;
  endfunction

  task automatic check_all();
    check("a_score",   64'(score_a),     64'(m[0].score));
    check("a_level",   64'(level_a),     64'(m[0].level));
    check("a_levelup", 64'(levelup_a),   64'(m[0].lu));
    check("a_playing", 64'(playing_a),   64'(m[0].st == 1));
    check("a_over",    64'(over_a),      64'(m[0].st == 2));
    check("a_sat",     64'(saturated_a), 64'(m[0].score == mx_score[0]));
    check("b_score",   64'(score_b),     64'(m[1].score));
    check("b_level",   64'(level_b),     64'(m[1].level));
    check("b_levelup", 64'(levelup_b),   64'(m[1].lu));
    check("b_playing", 64'(playing_b),   64'(m[1].st == 1));
    check("b_over",    64'(over_b),      64'(m[1].st == 2));
    check("b_sat",     64'(saturated_b), 64'(m[1].score == mx_score[1]));
`ifdef SCORE_HISCORE_EN
    check("a_hiscore", 64'(hiscore_a), 64'(m[0].hi));
    check("a_new_hi",  64'(new_hi_a),  64'(m[0].nh));
    check("b_hiscore", 64'(hiscore_b), 64'(m[1].hi));
    check("b_new_hi",  64'(new_hi_b),  64'(m[1].nh));
`endif
  endtask

  // Called at a falling edge: drive, clock, update model, compare at next falling edge.
  task automatic cyc(input bit s, input bit g, input bit e, input int p);
    start = s; gameover = g; evt = e; evt_points = 4'(p);
    @(posedge clk);
    for (int i = 0; i < 2; i++) mdl_step(i, s, g, e, p);
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_evt(input int p);
    cyc(1'b0, 1'b0, 1'b1, p);
    cyc(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    mx_score[0] = 64'hFFFF_FFFF; mx_level[0] = 15;
    mx_score[1] = 64'hFF;        mx_level[1] = 2;
    for (int i = 0; i < 2; i++) mdl_reset(i);

    @(negedge clk);
    check("rst_score", 64'(score_a), 64'd0);
    check("rst_state_idle", 64'({playing_a, over_a}), 64'd0);
    check_all();
    rst = 1'b0;

    // single rise held high counts once
    cyc(1'b1, 1'b0, 1'b0, 0);
    check("start_playing", 64'(playing_a), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 3);
    check("first_evt_score", 64'(score_a), 64'd3);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 3);
    check("held_evt_once", 64'(score_a), 64'd3);
    cyc(1'b0, 1'b0, 1'b0, 0);

    // five more 3-point events: sixth crosses the step
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 3);
      if (k == 5) begin
        check("lvl_up_score", 64'(score_a), 64'd18);
        check("lvl_up_level", 64'(level_a), 64'd1);
        check("lvl_up_pulse", 64'(levelup_a), 64'd1);
      end
      cyc(1'b0, 1'b0, 1'b0, 0);
      if (k == 5) check("lvl_up_one_cycle", 64'(levelup_a), 64'd0);
    end

    // gameover beats a simultaneous edge; OVER ignores edges
    cyc(1'b0, 1'b1, 1'b1, 3);
    check("go_over", 64'(over_a), 64'd1);
    check("go_drops_evt", 64'(score_a), 64'd18);
    cyc(1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, 5);
    check("over_ignores_evt", 64'(score_a), 64'd18);
    cyc(1'b1, 1'b0, 1'b0, 0);
    check("restart_clear", 64'({score_a, level_a}), 64'd0);

    // saturation on the 8-bit instance and MAX_LEVEL=2 hold
    for (int k = 0; k < 16; k++) pulse_evt(15);
    pulse_evt(10);
    check("preload_250", 64'(score_b), 64'd250);
    cyc(1'b0, 1'b0, 1'b1, 9);
    check("sat_score", 64'(score_b), 64'd255);
    check("sat_flag", 64'(saturated_b), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 0);
    pulse_evt(15);
    check("sat_hold", 64'(score_b), 64'd255);
    check("max_level_hold", 64'(level_b), 64'd2);
    check("a_level_max", 64'(level_a), 64'd15);

    // two games: 40 then 25
    cyc(1'b1, 1'b0, 1'b0, 0);
    pulse_evt(15); pulse_evt(15); pulse_evt(10);
    cyc(1'b0, 1'b1, 1'b0, 0);
`ifdef SCORE_HISCORE_EN
    check("hi_first", 64'(hiscore_a), 64'd40);
    check("new_hi_first", 64'(new_hi_a), 64'd1);
`endif
    cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    pulse_evt(15); pulse_evt(10);
    cyc(1'b0, 1'b1, 1'b0, 0);
    check("second_game_score", 64'(score_a), 64'd25);
`ifdef SCORE_HISCORE_EN
    check("hi_kept", 64'(hiscore_a), 64'd40);
    check("new_hi_second", 64'(new_hi_a), 64'd0);
`endif

    // gameover held across start: PLAY for one cycle, then OVER
    cyc(1'b1, 1'b1, 1'b0, 0);
    check("held_go_play", 64'(playing_a), 64'd1);
    cyc(1'b0, 1'b1, 1'b0, 0);
    check("held_go_over", 64'(over_a), 64'd1);

    // randomized play
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int n = 0; n < 3000; n++) begin
      cyc(bit'($urandom_range(0, 99) < 2), bit'($urandom_range(0, 99) < 3),
          bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end

    // asynchronous reset mid-game
    cyc(1'b1, 1'b0, 1'b0, 0);
    pulse_evt(7); pulse_evt(12);
    start = 1'b0; gameover = 1'b0; evt = 1'b0; evt_points = 4'd0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) mdl_reset(i);
    check("async_rst_score", 64'(score_a), 64'd0);
    check("async_rst_level", 64'(level_a), 64'd0);
    check("async_rst_idle", 64'({playing_a, over_a}), 64'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 5);
    check("idle_ignores_evt", 64'(score_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
